mul_seq_disp: RTL

Parametrised sequential shift-add multiplier with a multiplexed, active-low hex seven-segment display driver. It replaces the fixed 2x2-bit combinational multiply-and-display board block. Operands are captured on a start pulse and multiplied over WIDTH cycles. The latched product is continuously scanned across DIGITS common-anode digits.

---
 rtl/mul_seq_disp_pkg.sv | 53 +++++
 rtl/mul_seq_disp_seg7_hex.sv | 14 +
 rtl/mul_seq_disp.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mul_seq_disp_pkg.sv
// Shared types and seven-segment constants for the sequential multiplier display block.
// Segment codes are active-low with dp off: bit7 = dp, bits6..0 = g..a.
package mul_seq_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] code;
        case (nibble)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mul_seq_disp_seg7_hex.sv
// Combinational hex-to-seven-segment decoder, active-low outputs, with a blank override.
module seg7_hex
    import mul_seq_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : hex_to_seg(nibble);
    end

endmodule

// File: rtl/mul_seq_disp.sv
// Shift-add sequential multiplier whose latched product is scanned across a
// multiplexed common-anode hex display with optional leading-zero blanking.
module mul_seq_disp
    import mul_seq_disp_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [7:0]           seg,
    output logic [DIGITS-1:0]    en
);

    localparam int PW     = 2 * WIDTH;
    localparam int NIB_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(WIDTH);
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);

    state_e              state_q, state_d;
    logic [PW-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]       product_q, product_d;

    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic [7:0]          seg_q, seg_d;

    logic [NIB_W-1:0]    prod_ext;
    logic [3:0]          cur_nibble;
    logic                cur_blank;
    logic                scan_last;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CALC;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Product is loaded on entry to DONE so it is valid alongside the done pulse.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = DONE;
                    product_d = acc_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prod_ext           = '0;
        prod_ext[PW-1:0]   = product_q;
        scan_last          = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d         = scan_last ? '0 : scan_cnt_q + 1'b1;
        dig_d              = dig_q;
        if (scan_last) begin
            dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
        end
        cur_nibble         = prod_ext[{dig_q, 2'b00} +: 4];
        // A digit is blank when it and every more significant nibble are zero.
        cur_blank          = BLANK_LZ && (dig_q != '0) && ((prod_ext >> {dig_q, 2'b00}) == '0);
        en_d               = '1;
        en_d[dig_q]        = 1'b0;
    end

    seg7_hex u_seg7_hex (
        .nibble (cur_nibble),
        .blank  (cur_blank),
        .seg    (seg_d)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
            scan_cnt_q <= '0;
            dig_q      <= '0;
            en_q       <= {{(DIGITS-1){1'b1}}, 1'b0};
            seg_q      <= SEG_0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
            scan_cnt_q <= scan_cnt_d;
            dig_q      <= dig_d;
            en_q       <= en_d;
            seg_q      <= seg_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;
    assign seg     = seg_q;
    assign en      = en_q;

endmodule
